between_to_uart: RTL
====================

Name: between_to_uart

Overview:
Downstream consumer of the inter-board parallel link (8 data lines, tsent strobe, trecieve acknowledge). It accepts bytes over a 4-phase handshake and buffers them in an internal circular buffer. It keeps a running CRC8 over every accepted byte and re-emits the buffered bytes as 8N1 UART frames on tx. It is the receive-side mirror of the link driver and sits between the link pins and the host COM port.

Parameters:
DEPTH, 16, buffer entries; power of 2, minimum 2
CLKS_PER_BIT, 1, clk cycles per UART bit; 1 when clk is already the baud clock
CRC_POLY, 8'h07, CRC8 polynomial, MSB-first, init 8'h00

Ports:
clk  in  1  system clock; all state on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
t_data  in  8  link data lines; sender holds them stable while tsent=1
tsent  in  1  link strobe from sender; asynchronous to clk
trecieve  out  1  link acknowledge to sender
enable  in  1  1 = accept new link bytes
tx_pause  in  1  1 = do not start a new UART frame
tx  out  1  UART serial out, idle high
crc  out  8  running CRC8 of accepted bytes
fifo_count  out  log2(DEPTH)+1  bytes currently buffered
busy  out  1  1 when the buffer is non-empty or the TX FSM is not idle

Behaviour:
- Reset values: trecieve=0, tx=1, crc=8'h00, fifo_count=0, busy=0, both FSMs idle, both pointers 0.
- tsent passes through a 2-flop synchronizer giving ts_s; the synchronizer also resets to 0.
- Handshake FSM:
  - H_IDLE: trecieve=0. If ts_s=1, enable=1 and fifo_count<DEPTH, then capture t_data, push it, update crc, go to H_ACK.
  - If the buffer is full or enable=0, stay in H_IDLE with no ack. This is the backpressure mechanism; bytes are never dropped.
  - H_ACK: trecieve=1. When ts_s=0, go to H_IDLE (trecieve=0 on the next cycle).
  - enable falling while in H_ACK does not abort the ack.
- Handshake latency: trecieve rises 3 clk edges after tsent rises (2 sync, 1 register). It falls 3 clk edges after tsent falls. At most one byte is accepted per tsent high phase.
- CRC update: crc_next = 8 iterations of {crc^byte}: shift left, XOR CRC_POLY if the outgoing MSB was 1.
- Buffer:
  - Circular with wrap-around on both pointers.
  - Push and pop in the same cycle are both honoured and fifo_count is unchanged.
  - A pop when empty cannot occur. A push when full cannot occur because of the handshake gating above.
  - Read data is taken combinationally at the read pointer.
- TX FSM:
  - T_IDLE: tx=1. If fifo_count>0 and tx_pause=0, pop the head into an 8-bit shift register and go to T_START.
  - T_START: tx=0 for CLKS_PER_BIT cycles.
  - T_DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - T_STOP: tx=1 for CLKS_PER_BIT cycles, then go to T_IDLE.
  - Back-to-back frames have one idle cycle between the stop bit and the next start bit.
  - tx_pause is sampled only in T_IDLE; a frame in progress always completes.
- busy = (fifo_count!=0) | (TX state != T_IDLE).
- Reset mid-operation:
  - Asserting reset mid-frame forces tx=1 on the same edge; the partial frame is abandoned and buffered bytes are discarded.
  - Asserting reset in H_ACK drops trecieve. The sender's byte counts as accepted only if reset deasserts after the push.
- Counters: bit counter is 3 bits; baud counter is sized to count 0..CLKS_PER_BIT-1 and wraps to 0.

Test Plan:
- Reset: assert reset for 2 cycles -> tx=1, trecieve=0, crc=8'h00, fifo_count=0, busy=0; release -> tx remains 1 indefinitely.
- Single byte: t_data=8'h31, tsent high until trecieve=1, then low.
  - trecieve rises exactly 3 edges after tsent and falls 3 edges after tsent falls.
  - crc=8'h97.
  - tx sequence with CLKS_PER_BIT=1 is 0,1,0,0,0,1,1,0,0,1.
- CRC check string: handshake "123456789" (8'h31..8'h39) -> crc=8'hF4. tx carries the 9 bytes in order, each 8N1 LSB-first.
- Backpressure: tx_pause=1, send 17 bytes 8'h00..8'h10.
  - The first 16 are acked and fifo_count=16.
  - The 17th holds trecieve=0.
  - Then set tx_pause=0 -> first frame pops, 8'h10 is acked within 4 cycles, and output order is 8'h00..8'h10.
- Simultaneous push/pop: buffer holds 1 byte, TX leaves T_IDLE on the same cycle a new byte is pushed -> fifo_count stays 1. Wrap-around verified after 40 bytes with no loss or reordering.
- Reset mid-frame: assert reset during bit 4 of frame 8'hA5 -> tx=1 before the next clk edge, fifo_count=0, crc=8'h00; no stale bits after release.

Source files
------------

// File: rtl/between_to_uart.sv
// Link-side receiver: accepts bytes over a 4-phase tsent/trecieve handshake, buffers them,
// keeps a running CRC8 and replays the buffered bytes as 8N1 UART frames on tx.
module between_to_uart #(
   parameter int          DEPTH        = 16,
   parameter int          CLKS_PER_BIT = 1,
   parameter logic [7:0]  CRC_POLY     = 8'h07
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               t_data,
   input  logic                     tsent,
   output logic                     trecieve,
   input  logic                     enable,
   input  logic                     tx_pause,
   output logic                     tx,
   output logic [7:0]               crc,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);

   typedef enum logic       {H_IDLE, H_ACK} h_state_t;
   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} t_state_t;

   function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] b);
      logic [7:0] r;
      r = c ^ b;
      for (int i = 0; i < 8; i++) begin
         r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
      end
      return r;
   endfunction

   logic           ts_meta_q, ts_s_q;
   h_state_t       h_state_q, h_state_d;
   t_state_t       t_state_q, t_state_d;
   logic           trecieve_q, trecieve_d;
   logic           tx_q, tx_d;
   logic [7:0]     crc_q, crc_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic [2:0]     bit_q, bit_d;
   logic [BW-1:0]  baud_q, baud_d;
   logic [7:0]     shift_q, shift_d;
   logic [7:0]     mem [DEPTH];
   logic [7:0]     rd_data;
   logic           push, pop;

   assign rd_data = mem[rd_ptr_q];

   always_comb begin
      h_state_d  = h_state_q;
      t_state_d  = t_state_q;
      trecieve_d = trecieve_q;
      tx_d       = tx_q;
      crc_d      = crc_q;
      bit_d      = bit_q;
      baud_d     = baud_q;
      shift_d    = shift_q;
      push       = 1'b0;
      pop        = 1'b0;

      // Handshake: a full buffer or enable=0 simply withholds the ack (backpressure).
      case (h_state_q)
         H_IDLE: begin
            if (ts_s_q && enable && (count_q < FULL)) begin
               push       = 1'b1;
               crc_d      = crc8_step(crc_q, t_data);
               h_state_d  = H_ACK;
               trecieve_d = 1'b1;
            end
         end
         default: begin
            if (!ts_s_q) begin
               h_state_d  = H_IDLE;
               trecieve_d = 1'b0;
            end
         end
      endcase

      case (t_state_q)
         T_IDLE: begin
            tx_d = 1'b1;
            if ((count_q != '0) && !tx_pause) begin
               pop       = 1'b1;
               shift_d   = rd_data;
               t_state_d = T_START;
               tx_d      = 1'b0;
               baud_d    = '0;
            end
         end
         T_START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d    = '0;
               bit_d     = 3'd0;
               t_state_d = T_DATA;
               tx_d      = shift_q[0];
               shift_d   = shift_q >> 1;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         T_DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  t_state_d = T_STOP;
                  tx_d      = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: begin
            if (baud_q == BAUD_LAST) begin
               baud_d    = '0;
               t_state_d = T_IDLE;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
      endcase

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_meta_q  <= 1'b0;
         ts_s_q     <= 1'b0;
         h_state_q  <= H_IDLE;
         t_state_q  <= T_IDLE;
         trecieve_q <= 1'b0;
         tx_q       <= 1'b1;
         crc_q      <= 8'h00;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         bit_q      <= 3'd0;
         baud_q     <= '0;
      end else begin
         ts_meta_q  <= tsent;
         ts_s_q     <= ts_meta_q;
         h_state_q  <= h_state_d;
         t_state_q  <= t_state_d;
         trecieve_q <= trecieve_d;
         tx_q       <= tx_d;
         crc_q      <= crc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         bit_q      <= bit_d;
         baud_q     <= baud_d;
      end
   end

   // Storage and the frame shifter hold data only; their contents are meaningless until written.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      if (push) begin
         mem[wr_ptr_q] <= t_data;
      end
   end

   assign trecieve   = trecieve_q;
   assign tx         = tx_q;
   assign crc        = crc_q;
   assign fifo_count = count_q;
   assign busy       = (count_q != '0) | (t_state_q != T_IDLE);

endmodule
